fir_output_stage: RTL and testbench
===================================

// Module: fir_output_stage
// PURPOSE
//  Sink for the FIR adder-tree accumulator: takes the full-width sum pulse (acc_in/acc_valid),
//  rounds and saturates it to the output sample width, and buffers it in a FIFO with a valid/ready
//  output. The adder tree cannot stall, so this block runs credit tracking: issue_ok tells the
//  sample feeder whether a new issue is guaranteed a FIFO slot when its sum lands.
// PARAMETERS
//  TAPS      401                  filter length (sets accumulator width)
//  MULTBITS  32                   product width into the accumulator
//  ACCUBITS  MULTBITS+$clog2(TAPS) accumulator sum width (41 at defaults), signed two's complement
//  SHIFT     15                   fractional bits removed by rounding; 0 = no rounding
//  OUTBITS   16                   output sample width, signed
//  DEPTH     16                   FIFO entries, power of 2, >= 2
// PORTS
//  clk        in   1                      clock, all logic on posedge
//  rst        in   1                      synchronous active-high reset
//  issue      in   1                      feeder drives in_valid into the adder tree this cycle
//  acc_in     in   ACCUBITS               accumulator sum, signed
//  acc_valid  in   1                      acc_in valid (single-cycle pulse per sum)
//  issue_ok   out  1                      credit available; feeder issues only when high
//  dout       out  OUTBITS                head-of-FIFO sample, signed
//  dout_valid out  1                      FIFO not empty
//  dout_ready in   1                      consumer accepts dout this cycle
//  count      out  $clog2(DEPTH+1)        FIFO occupancy
//  sat_flag   out  1                      sticky: some sample saturated
//  overflow   out  1                      sticky: sample dropped, FIFO full
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): FIFO ptrs, count, inflight, round-stage valid, sat_flag, overflow
//   all 0 -> dout_valid=0, count=0, issue_ok=1, dout=0 on the cycle after reset.
//  Round stage (1 reg): r = (acc_in + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, computed in ACCUBITS+1
//   bits (no wrap); clamp to [-2^(OUTBITS-1), 2^(OUTBITS-1)-1]; clamping sets sat_flag.
//   Round-half-up toward +inf (e.g. -0.5 LSB -> 0).
//  Latency: acc_valid at cycle N -> round reg valid N+1 -> FIFO write at N+1 edge -> dout_valid at N+2
//   when FIFO was empty. FIFO is show-ahead: dout = head entry whenever dout_valid=1.
//  Read: pop when dout_valid & dout_ready. dout_ready with empty FIFO is ignored.
//  Write: round-stage valid writes at tail. If full and no pop same cycle -> sample dropped,
//   overflow=1, count stays DEPTH. Full with simultaneous pop -> write accepted, count unchanged.
//  Ptrs wrap modulo DEPTH; count = writes - pops, range 0..DEPTH.
//  Credit: inflight counter (0..DEPTH) +1 on issue, -1 on round-stage write attempt; both same cycle
//   -> unchanged. Saturates at 0 (no underflow from post-reset stragglers) and at DEPTH.
//   issue_ok = (count + inflight) < DEPTH, from registered state only (no comb path from inputs).
//  Reset mid-operation: all buffered and in-flight data discarded; acc_valid pulses arriving
//   after reset are processed normally (written if space) and do not underflow inflight.
//  Flags clear only on rst.
// TESTING (SHIFT=15, OUTBITS=16, DEPTH=16, dout_ready=1 unless stated)
//  Rounding: acc_in=16384 -> dout=1; 16383 -> 0; -16384 -> 0; -16385 -> -1; each dout_valid 2 cycles
//   after acc_valid, sat_flag stays 0.
//  Saturation: acc_in=2^40-1 -> dout=0x7FFF, sat_flag=1; acc_in=-2^40 -> dout=0x8000.
//  Credit: dout_ready=0, pulse issue each cycle while issue_ok, tree model returns acc_valid 9 cycles
//   later -> exactly 16 issues, issue_ok=0 after 16th, count ends 16, overflow=0; then ready=1 ->
//   16 samples drain in issue order, issue_ok returns 1 the cycle after first pop.
//  Overflow: dout_ready=0, 17 acc_valid pulses ignoring issue_ok -> count=16, overflow=1, 17th lost.
//  Full + simultaneous: count=16, write and pop same cycle -> count stays 16, new sample at tail,
//   overflow stays 0.
//  Reset mid-stream: count=8, inflight=3, assert rst 1 cycle -> next cycle count=0, dout_valid=0,
//   issue_ok=1, flags 0; 3 late acc_valid pulses -> count=3, inflight stays 0.

Source files
------------

// File: rtl/fir_output_stage.sv
// fir_output_stage: output sink for the FIR adder-tree accumulator.
//   Rounds (half-up) and saturates each full-width sum to OUTBITS. Results go into a
//   show-ahead FIFO with a valid/ready output. Credit tracking (inflight) tells the
//   feeder when an issue is guaranteed a FIFO slot, because the tree cannot stall.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   issue            feeder issues a sample into the adder tree this cycle
//   acc_in/acc_valid accumulator sum (signed) and its single-cycle valid pulse
//   issue_ok         credit available (registered state only)
//   dout/dout_valid  head-of-FIFO sample / FIFO not empty
//   dout_ready       consumer accepts dout
//   count            FIFO occupancy
//   sat_flag         sticky: some sample was clamped
//   overflow         sticky: a sample was dropped on a full FIFO
module fir_output_stage #(
    parameter int unsigned TAPS     = 401,
    parameter int unsigned MULTBITS = 32,
    parameter int unsigned ACCUBITS = MULTBITS + $clog2(TAPS),
    parameter int unsigned SHIFT    = 15,
    parameter int unsigned OUTBITS  = 16,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    input  logic signed [ACCUBITS-1:0]   acc_in,
    input  logic                         acc_valid,
    output logic                         issue_ok,
    output logic [OUTBITS-1:0]           dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         sat_flag,
    output logic                         overflow
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACCUBITS:0] RndOne = {{ACCUBITS{1'b0}}, 1'b1};
    localparam logic signed [ACCUBITS:0] Rnd    = (SHIFT > 0) ? (RndOne << RndPos) : '0;
    localparam logic signed [ACCUBITS:0] SatMax =
        {{(ACCUBITS - OUTBITS + 2){1'b0}}, {(OUTBITS - 1){1'b1}}};
    localparam logic signed [ACCUBITS:0] SatMin =
        {{(ACCUBITS - OUTBITS + 2){1'b1}}, {(OUTBITS - 1){1'b0}}};
    localparam logic [CW-1:0] DepthW = CW'(DEPTH);
    localparam logic [CW:0]   DepthX = (CW + 1)'(DEPTH);

    // Round / saturate (combinational part feeding the round register)
    logic signed [ACCUBITS:0] acc_ext, acc_rnd, acc_shr;
    logic [OUTBITS-1:0]       sat_val;
    logic                     sat_hit;

    always_comb begin
        acc_ext = {acc_in[ACCUBITS-1], acc_in};
        // One extra bit so adding the rounding constant can never wrap
        acc_rnd = acc_ext + Rnd;
        acc_shr = acc_rnd >>> SHIFT;
        sat_hit = 1'b0;
        sat_val = acc_shr[OUTBITS-1:0];
        if (acc_shr > SatMax) begin
            sat_hit = 1'b1;
            sat_val = SatMax[OUTBITS-1:0];
        end else if (acc_shr < SatMin) begin
            sat_hit = 1'b1;
            sat_val = SatMin[OUTBITS-1:0];
        end
    end

    // State
    logic               rnd_valid_q;
    logic [OUTBITS-1:0] rnd_data_q;
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d, inflight_q, inflight_d;
    logic               sat_flag_q, sat_flag_d, overflow_q, overflow_d;
    logic [OUTBITS-1:0] mem_q [DEPTH];

    logic full, pop, wr_en, drop;

    always_comb begin
        full       = (count_q == DepthW);
        pop        = (count_q != '0) && dout_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        wr_en      = rnd_valid_q && (!full || pop);
        drop       = rnd_valid_q && full && !pop;

        wptr_d     = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;

        count_d    = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        // Credits return on the write attempt, whether or not the write succeeded.
        // Saturation at 0 absorbs sums still in the tree when reset hit.
        inflight_d = inflight_q;
        if (issue && !rnd_valid_q && inflight_q != DepthW) begin
            inflight_d = inflight_q + CW'(1);
        end else if (rnd_valid_q && !issue && inflight_q != '0) begin
            inflight_d = inflight_q - CW'(1);
        end

        sat_flag_d = sat_flag_q | (acc_valid & sat_hit);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            sat_flag_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rnd_valid_q <= acc_valid;
            if (acc_valid) begin
                rnd_data_q <= sat_val;
            end
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            sat_flag_q  <= sat_flag_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; dout is gated by dout_valid instead
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= rnd_data_q;
        end
    end

    always_comb begin
        dout_valid = (count_q != '0);
        dout       = dout_valid ? mem_q[rptr_q] : '0;
        count      = count_q;
        issue_ok   = ({1'b0, count_q} + {1'b0, inflight_q}) < DepthX;
        sat_flag   = sat_flag_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed self-checking bench for fir_output_stage at default parameters.
module tb_fir_output_stage;

    localparam int AB = 41;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue;
    logic [AB-1:0] acc_in;
    logic          acc_valid;
    logic          issue_ok;
    logic [15:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [4:0]    count;
    logic          sat_flag;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fir_output_stage dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .issue_ok   (issue_ok),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .sat_flag   (sat_flag),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [AB-1:0] v);
        acc_in    = v;
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Sample k encoded so rounding yields exactly k
    function automatic logic [AB-1:0] enc(input int k);
        logic signed [AB-1:0] v;
        v = AB'(k) <<< 15;
        return v;
    endfunction

    initial begin
        logic [AB-1:0] rnd_in  [4];
        logic [15:0]   rnd_exp [4];
        int            issues;
        int            due_q[$];
        int            val_q[$];
        int            seq;

        rnd_in[0] = AB'(16384);  rnd_exp[0] = 16'h0001;
        rnd_in[1] = AB'(16383);  rnd_exp[1] = 16'h0000;
        rnd_in[2] = AB'(-16384); rnd_exp[2] = 16'h0000;
        rnd_in[3] = AB'(-16385); rnd_exp[3] = 16'hFFFF;

        issue = 1'b0; acc_in = '0; acc_valid = 1'b0; dout_ready = 1'b1; rst = 1'b1;
        step();
        do_reset();

        check_eq("rst_dout_valid", dout_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_issue_ok", issue_ok, 1);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_sat", sat_flag, 0);
        check_eq("rst_ovf", overflow, 0);

        // Rounding: dout_valid exactly two cycles after acc_valid
        for (int i = 0; i < 4; i++) begin
            pulse(rnd_in[i]);
            check_eq($sformatf("rnd%0d_not_yet", i), dout_valid, 0);
            step();
            check_eq($sformatf("rnd%0d_valid", i), dout_valid, 1);
            check_eq($sformatf("rnd%0d_dout", i), dout, rnd_exp[i]);
            step();
        end
        check_eq("rnd_no_sat", sat_flag, 0);

        // Saturation
        pulse({1'b0, {40{1'b1}}});
        step();
        check_eq("sat_pos", dout, 16'h7FFF);
        check_eq("sat_flag", sat_flag, 1);
        step();
        pulse({1'b1, {40{1'b0}}});
        step();
        check_eq("sat_neg", dout, 16'h8000);
        step();

        // Credit: tree model returns each issue 9 cycles later
        do_reset();
        dout_ready = 1'b0;
        issues = 0; seq = 0;
        for (int k = 0; k < 60; k++) begin
            issue = issue_ok;
            if (issue) begin
                seq++;
                issues++;
                due_q.push_back(cyc + 9);
                val_q.push_back(seq);
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                acc_valid = 1'b1;
                acc_in    = enc(val_q[0]);
                void'(due_q.pop_front());
                void'(val_q.pop_front());
            end else begin
                acc_valid = 1'b0;
            end
            step();
        end
        issue = 1'b0; acc_valid = 1'b0;
        check_eq("credit_issues", 64'(issues), 16);
        check_eq("credit_blocked", issue_ok, 0);
        check_eq("credit_count", count, 16);
        check_eq("credit_ovf", overflow, 0);
        dout_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check_eq($sformatf("credit_drain%0d", i), dout, 16'(i));
            step();
            if (i == 1) check_eq("credit_back", issue_ok, 1);
        end
        check_eq("credit_empty", count, 0);

        // Overflow: 17 pulses into a stalled FIFO
        do_reset();
        dout_ready = 1'b0;
        for (int i = 1; i <= 17; i++) pulse(enc(i));
        step();
        step();
        check_eq("ovf_count", count, 16);
        check_eq("ovf_flag", overflow, 1);
        dout_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check_eq($sformatf("ovf_drain%0d", i), dout, 16'(i));
            step();
        end
        check_eq("ovf_lost17", dout_valid, 0);

        // Full with simultaneous write and pop
        do_reset();
        dout_ready = 1'b0;
        for (int i = 1; i <= 16; i++) pulse(enc(i));
        step();
        step();
        check_eq("fs_full", count, 16);
        pulse(enc(100));
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check_eq("fs_count", count, 16);
        check_eq("fs_ovf", overflow, 0);
        check_eq("fs_head", dout, 16'd2);
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("fs_drain%0d", i), dout, (i == 15) ? 16'd100 : 16'(i + 2));
            step();
        end

        // Reset mid-stream: 8 buffered, 3 in flight
        do_reset();
        dout_ready = 1'b0;
        pulse({1'b0, {40{1'b1}}});
        for (int i = 2; i <= 8; i++) pulse(enc(i));
        step();
        step();
        check_eq("mid_count8", count, 8);
        issue = 1'b1;
        step(); step(); step();
        issue = 1'b0;
        check_eq("mid_sat_before", sat_flag, 1);
        do_reset();
        check_eq("mid_count", count, 0);
        check_eq("mid_valid", dout_valid, 0);
        check_eq("mid_issue_ok", issue_ok, 1);
        check_eq("mid_sat", sat_flag, 0);
        check_eq("mid_ovf", overflow, 0);
        for (int i = 5; i <= 7; i++) pulse(enc(i));
        step();
        step();
        check_eq("mid_late_count", count, 3);
        check_eq("mid_late_head", dout, 16'd5);
        // Inflight must be 0: exactly 13 more issues fit
        issues = 0;
        for (int k = 0; k < 20; k++) begin
            issue = issue_ok;
            if (issue) issues++;
            step();
        end
        issue = 1'b0;
        check_eq("mid_inflight0", 64'(issues), 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
